// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and load/store sequencer for dmem
// Grants one byte/half/word request per two cycles and returns extended load data.
module dmem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [1:0]  m0_size,
   input  logic        m0_unsigned,
   input  logic [31:0] m0_wdata,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [1:0]  m1_size,
   input  logic        m1_unsigned,
   input  logic [31:0] m1_wdata,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [29:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write_flag,
   output logic        mem_enable,
   input  logic [31:0] mem_read_data
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic        last_grant_q;
   logic        port_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [3:0]  flag_q, flag_d;
   logic [31:0] wrep_q, wrep_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic        grant0, grant1, take;
   logic        sel_we, sel_uns;
   logic [31:0] sel_addr, sel_wdata;
   logic [1:0]  sel_size;
   logic        acc_err;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] load_val;

   // On a tie the port that did not win last time gets the grant.
   assign grant0 = m0_valid & (~m1_valid | last_grant_q);
   assign grant1 = m1_valid & (~m0_valid | ~last_grant_q);
   assign take     = (state_q == IDLE) & (grant0 | grant1);
   assign m0_ready = (state_q == IDLE) & grant0;
   assign m1_ready = (state_q == IDLE) & grant1;

   assign sel_we    = grant1 ? m1_we       : m0_we;
   assign sel_addr  = grant1 ? m1_addr     : m0_addr;
   assign sel_size  = grant1 ? m1_size     : m0_size;
   assign sel_uns   = grant1 ? m1_unsigned : m0_unsigned;
   assign sel_wdata = grant1 ? m1_wdata    : m0_wdata;

   always_comb begin
      flag_d = 4'b1111;
      wrep_d = sel_wdata;
      case (sel_size)
         2'b00: begin
            flag_d = 4'b0001 << sel_addr[1:0];
            wrep_d = {4{sel_wdata[7:0]}};
         end
         2'b01: begin
            flag_d = sel_addr[1] ? 4'b1100 : 4'b0011;
            wrep_d = {2{sel_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign acc_err = (size_q == 2'b11) | ((size_q == 2'b01) & addr_q[0]) |
                    ((size_q == 2'b10) & (addr_q[1:0] != 2'b00));

   assign mem_address    = addr_q[31:2];
   assign mem_write_flag = flag_q;
   assign mem_write_data = wrep_q;
   assign mem_enable     = (state_q == ACCESS) & we_q & ~acc_err;

   assign rd_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
   assign rd_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];

   always_comb begin
      load_val = mem_read_data;
      case (size_q)
         2'b00:   load_val = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
         2'b01:   load_val = {{16{rd_half[15] & ~uns_q}}, rd_half};
         default: ;
      endcase
      if (acc_err || we_q) load_val = 32'h0;
   end

   always_comb begin
      state_d  = state_q;
      rvalid_d = 2'b00;
      err_d    = 2'b00;
      rdata0_d = 32'h0;
      rdata1_d = 32'h0;
      case (state_q)
         IDLE:   if (take) state_d = ACCESS;
         ACCESS: begin
            state_d = IDLE;
            rvalid_d[port_q] = 1'b1;
            err_d[port_q]    = acc_err;
            if (port_q) rdata1_d = load_val;
            else        rdata0_d = load_val;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         flag_q       <= 4'h0;
         wrep_q       <= 32'h0;
         rvalid_q     <= 2'b00;
         err_q        <= 2'b00;
         rdata0_q     <= 32'h0;
         rdata1_q     <= 32'h0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         if (take) begin
            last_grant_q <= grant1;
            port_q       <= grant1;
            we_q         <= sel_we;
            addr_q       <= sel_addr;
            size_q       <= sel_size;
            uns_q        <= sel_uns;
            flag_q       <= flag_d;
            wrep_q       <= wrep_d;
         end
      end
   end

   assign m0_rvalid = rvalid_q[0];
   assign m1_rvalid = rvalid_q[1];
   assign m0_err    = err_q[0];
   assign m1_err    = err_q[1];
   assign m0_rdata  = rdata0_q;
   assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
// A small word memory model stands in for dmem.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m0_ready, m0_we, m0_unsigned, m0_rvalid, m0_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [1:0]  m0_size;
   logic        m1_valid, m1_ready, m1_we, m1_unsigned, m1_rvalid, m1_err;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [1:0]  m1_size;
   logic [29:0] mem_address;
   logic [31:0] mem_write_data, mem_read_data;
   logic [3:0]  mem_write_flag;
   logic        mem_enable;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_size(m0_size), .m0_unsigned(m0_unsigned), .m0_wdata(m0_wdata),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_size(m1_size), .m1_unsigned(m1_unsigned), .m1_wdata(m1_wdata),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_write_flag(mem_write_flag), .mem_enable(mem_enable),
      .mem_read_data(mem_read_data)
   );

   logic [31:0] tmem [0:255];
   assign mem_read_data = tmem[mem_address[7:0]];
   always @(posedge clk) begin
      if (mem_enable) begin
         for (int b = 0; b < 4; b++)
            if (mem_write_flag[b]) tmem[mem_address[7:0]][8*b +: 8] = mem_write_data[8*b +: 8];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic p, input logic v, input logic we, input logic [31:0] a,
                        input logic [1:0] s, input logic u, input logic [31:0] w);
      if (p) begin
         m1_valid = v; m1_we = we; m1_addr = a; m1_size = s; m1_unsigned = u; m1_wdata = w;
      end else begin
         m0_valid = v; m0_we = we; m0_addr = a; m0_size = s; m0_unsigned = u; m0_wdata = w;
      end
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_flag;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vt [14];

   task automatic run_vec(input vec_t v);
      logic got;
      drive(v.port, 1'b1, v.we, v.addr, v.size, v.uns, v.wdata);
      #1;
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if ((v.port ? m1_ready : m0_ready) === 1'b1) begin
            got = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      chk("ready", {31'h0, got}, 32'h1);
      @(posedge clk); #1;
      drive(v.port, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      chk("access_addr", {2'b00, mem_address}, {2'b00, v.addr[31:2]});
      chk("access_en", {31'h0, mem_enable}, {31'h0, v.we & ~v.exp_err});
      if (v.we && !v.exp_err) begin
         chk("access_flag", {28'h0, mem_write_flag}, {28'h0, v.exp_flag});
         chk("access_wdata", mem_write_data, v.exp_wdata);
      end
      chk("access_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      @(posedge clk); #1;
      chk("rvalid_own", {31'h0, v.port ? m1_rvalid : m0_rvalid}, 32'h1);
      chk("rvalid_other", {31'h0, v.port ? m0_rvalid : m1_rvalid}, 32'h0);
      chk("rdata", v.port ? m1_rdata : m0_rdata, v.exp_rdata);
      chk("err", {31'h0, v.port ? m1_err : m0_err}, {31'h0, v.exp_err});
      chk("rdata_other", v.port ? m0_rdata : m1_rdata, 32'h0);
      @(posedge clk); #1;
      chk("rvalid_pulse", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      @(negedge clk);
   endtask

   int          grants [4];
   int          ng, due_cyc, due_port;
   logic [31:0] arb_exp [2];

   initial begin
      for (int i = 0; i < 256; i++) tmem[i] = 32'h0;
      tmem[8'h41] = 32'h12345678;
      tmem[8'h80] = 32'hCAFEF00D;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);

      //             port we   addr          sz     uns   wdata         rdata         err   flag     wrep
      vt[0]  = '{1'b0, 1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
      vt[1]  = '{1'b0, 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 4'b0000, 32'h0};
      vt[2]  = '{1'b1, 1'b1, 32'h0000_0103, 2'b00, 1'b0, 32'h12345680, 32'h0,        1'b0, 4'b1000, 32'h80808080};
      vt[3]  = '{1'b0, 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 4'b0000, 32'h0};
      vt[4]  = '{1'b1, 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0,        32'h00000080, 1'b0, 4'b0000, 32'h0};
      vt[5]  = '{1'b0, 1'b0, 32'h0000_0102, 2'b01, 1'b0, 32'h0,        32'hFFFF80AD, 1'b0, 4'b0000, 32'h0};
      vt[6]  = '{1'b0, 1'b0, 32'h0000_0101, 2'b00, 1'b0, 32'h0,        32'hFFFFFFBE, 1'b0, 4'b0000, 32'h0};
      vt[7]  = '{1'b1, 1'b0, 32'h0000_0100, 2'b01, 1'b1, 32'h0,        32'h0000BEEF, 1'b0, 4'b0000, 32'h0};
      vt[8]  = '{1'b0, 1'b1, 32'h0000_0106, 2'b01, 1'b0, 32'hAAAA7FFF, 32'h0,        1'b0, 4'b1100, 32'h7FFF7FFF};
      vt[9]  = '{1'b1, 1'b0, 32'h0000_0106, 2'b01, 1'b0, 32'h0,        32'h00007FFF, 1'b0, 4'b0000, 32'h0};
      vt[10] = '{1'b0, 1'b1, 32'h0000_0102, 2'b10, 1'b0, 32'h11111111, 32'h0,        1'b1, 4'b0000, 32'h0};
      vt[11] = '{1'b1, 1'b0, 32'h0000_0101, 2'b01, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
      vt[12] = '{1'b0, 1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0};
      vt[13] = '{1'b0, 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0, 4'b0000, 32'h0};

      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      chk("rst_err", {30'h0, m1_err, m0_err}, 32'h0);
      chk("rst_rdata0", m0_rdata, 32'h0);
      chk("rst_rdata1", m1_rdata, 32'h0);
      chk("rst_en", {31'h0, mem_enable}, 32'h0);
      chk("rst_addr", {2'b00, mem_address}, 32'h0);
      chk("rst_flag", {28'h0, mem_write_flag}, 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 14; i++) run_vec(vt[i]);

      // Store aborted by an asynchronous reset in the middle of ACCESS.
      drive(1'b0, 1'b1, 1'b1, 32'h0000_0200, 2'b10, 1'b0, 32'h55555555);
      #1;
      chk("abort_ready", {31'h0, m0_ready}, 32'h1);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
      chk("abort_en_before", {31'h0, mem_enable}, 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("abort_en_after", {31'h0, mem_enable}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      chk("abort_mem_kept", tmem[8'h80], 32'hCAFEF00D);
      @(negedge clk);

      // Both ports valid continuously; first tie after reset goes to port 0.
      arb_exp[0] = 32'h80ADBEEF;
      arb_exp[1] = 32'h7FFF5678;
      drive(1'b0, 1'b1, 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0);
      ng = 0;
      due_cyc = -1;
      due_port = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         #1;
         if (cyc == due_cyc) begin
            chk("arb_rvalid", {30'h0, m1_rvalid, m0_rvalid}, due_port ? 32'h2 : 32'h1);
            chk("arb_rdata", due_port ? m1_rdata : m0_rdata, arb_exp[due_port]);
         end else begin
            chk("arb_quiet", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
         end
         if (m0_ready && m1_ready) chk("arb_both_ready", 32'h1, 32'h0);
         if (ng < 4 && (m0_ready || m1_ready)) begin
            grants[ng] = m1_ready ? 1 : 0;
            due_port = grants[ng];
            due_cyc = cyc + 2;
            ng++;
         end
         @(negedge clk);
         if (ng == 4) begin
            drive(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
         end
         if (ng == 4 && cyc >= due_cyc) break;
      end
      chk("arb_count", ng, 32'd4);
      for (int i = 0; i < 4; i++) chk("arb_order", grants[i], i % 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and load/store sequencer in front of `dmem`. It accepts byte, halfword and word requests from the CPU load/store unit (port 0) and the debug/loader port (port 1), and grants them round-robin. It drives the word-addressed `dmem` port with the write byte-lane flags and replicated write data. It returns aligned, sign- or zero-extended read data one cycle after the memory access.

## Interface
- No parameters; address 32-bit, data 32-bit, fixed.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mN_valid`  in  1  request valid, N∈{0,1}; held with its fields until `mN_ready`.
- `mN_ready`  out  1  request accepted this cycle.
- `mN_we`  in  1  1=store, 0=load.
- `mN_addr`  in  32  byte address.
- `mN_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `mN_unsigned`  in  1  zero-extend loads when 1.
- `mN_wdata`  in  32  store data, right-aligned.
- `mN_rvalid`  out  1  one-cycle response pulse (loads and stores).
- `mN_rdata`  out  32  extended load data; 0 for stores and errors.
- `mN_err`  out  1  misaligned/illegal flag, valid with `mN_rvalid`.
- `mem_address`  out  30  word address [31:2] to `dmem`.
- `mem_write_data`  out  32  lane-replicated store data.
- `mem_write_flag`  out  4  byte-lane write enables.
- `mem_enable`  out  1  write enable to `dmem`.
- `mem_read_data`  in  32  combinational `dmem` read output.

## Operation
- FSM states: IDLE, ACCESS.
- **IDLE: arbitration.**
  - If exactly one `mN_valid` is high, that port is granted.
  - If both are high, the port not equal to `last_grant` is granted.
  - `mN_ready` = (state==IDLE) & granted; it is combinational.
  - On the handshake, latch we/addr/size/unsigned/wdata/port, set `last_grant`=port, and go to ACCESS.
- **ACCESS:**
  - Drive `mem_address`=latched addr[31:2].
  - `mem_enable` = we & ~err.
  - Always return to IDLE next cycle.
- **Error condition.** err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0). An errored access never writes.
- **Store lanes:**
  - Byte: flag=0001<<addr[1:0]; data={4{wdata[7:0]}}.
  - Half: flag = addr[1] ? 1100 : 0011; data={2{wdata[15:0]}}.
  - Word: flag=1111; data=wdata.
  - Flags and data are held from the latch in both states. `dmem` only writes while `mem_enable`=1.
- **Load extract** (at the end of ACCESS, from `mem_read_data`):
  - Byte lane = addr[1:0].
  - Half lane = addr[1].
  - Extend with sign bit (bit 7 or bit 15) unless `unsigned`.
  - Word is passed through.
- **Response.** At the end of ACCESS, register rdata/err for the latched port and pulse its `rvalid`. The other port's response outputs stay 0.
- **Reset values:**
  - State IDLE, `last_grant`=1 (port 0 wins the first tie).
  - All `mN_rvalid`/`mN_err`=0, `mN_rdata`=0.
  - `mem_enable`=0, `mem_address`=0, `mem_write_flag`=0, `mem_write_data`=0.

## Timing
- **Latency.** Handshake in cycle N → ACCESS in N+1 → `mN_rvalid` high in N+2.
- **Throughput.** One access per 2 cycles. A new handshake may occur in N+2, concurrent with the response pulse.
- **Write window.** `mem_enable` is high for exactly one cycle (ACCESS). The address and flags are registered and stable for that whole cycle, which is required because `dmem` writes level-sensitively.
- **Simultaneous requests.** Alternating grants; neither port starves. A continuously-valid port waits at most one access.
- **Handshake rule.** `mN_valid` may drop only after `mN_ready`. Field changes before acceptance are ignored until the accept cycle.
- **Reset during ACCESS.** `mem_enable` drops immediately (asynchronous); no `rvalid` is issued for the aborted access.
- **Store-to-load ordering.** A load issued after a store to the same word sees the new data, because the write completes in ACCESS before the next IDLE.

## Test plan
- **Word store/load, port 0:**
  - Stimulus: store 0xDEADBEEF to 0x100, then load word from 0x100.
  - Required: `mem_write_flag`=1111 for one cycle; load `m0_rdata`=0xDEADBEEF at handshake+2; `m0_err`=0.
- **Byte/half lanes:**
  - Stimulus: store byte 0x80 to 0x103, then signed byte load, unsigned byte load and signed half load from 0x102.
  - Required: flag 1000; loads return 0xFFFFFF80, 0x00000080, and 0xFFFF80xx (xx = old byte 2).
- **Misaligned:**
  - Stimulus: word store to 0x102, then half load from 0x101.
  - Required: `mem_enable` stays 0; `rvalid`=1, `err`=1, `rdata`=0 for both.
- **Arbitration:**
  - Stimulus: both ports valid continuously for 4 requests.
  - Required: grants in order 0,1,0,1; each `rvalid` lands only on the owning port.
- **Reset in ACCESS:**
  - Stimulus: assert `rst` mid-cycle during a store's ACCESS.
  - Required: `mem_enable` falls at once; no `rvalid`; the first request after reset is accepted normally.
